// File: rtl/fir_out_serializer_pkg.sv
// Shared FIR definitions: sample width, FIFO depth default, output FSM encoding.
package fir_out_serializer_pkg;

    // Width of one FIR output sample (unfolded filter output width).
    localparam int FIR_NB    = 8;

    // Default number of triplets buffered between the filter and the sink.
    localparam int FIR_DEPTH = 4;

    // Phase index of the last word of a triplet (words are 0, 1, 2).
    localparam logic [1:0] PHASE_LAST = 2'd2;

    // Output serializer states.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } emit_state_e;

endpackage

// File: rtl/fir_triplet_fifo.sv
// Triplet FIFO: DEPTH entries of W bits, power-of-two depth, explicit occupancy
// counter so full and empty never alias. Exposes the head and the entry behind
// it so the reader can chain triplets without a bubble.
module fir_triplet_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [W-1:0]  next_head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_inc;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push    = push && (!full || pop);
    assign do_pop     = pop && !empty;
    assign rd_ptr_inc = rd_ptr + PTR_ONE;

    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr_inc];
    assign full      = (count == CNT_DEPTH);
    assign empty     = (count == '0);

    // Storage array: written at the tail, never reset (occupancy gates reads).
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy holds on push+pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// Converts the unfolded FIR's parallel output triplets {y[3k], y[3k+1], y[3k+2]}
// into one sample per cycle. Triplets are buffered in a small FIFO; an IDLE/EMIT
// FSM with a 0..2 phase counter walks the head triplet and chains the next one
// without an idle cycle. Triplets arriving into a full FIFO are dropped and
// flagged in a sticky OVF bit.
module fir_out_serializer
    import fir_out_serializer_pkg::*;
#(
    parameter int NB    = FIR_NB,
    parameter int DEPTH = FIR_DEPTH
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          VIN,
    input  logic [NB-1:0] DIN0,
    input  logic [NB-1:0] DIN1,
    input  logic [NB-1:0] DIN2,
    output logic [NB-1:0] DOUT,
    output logic          VOUT,
    output logic          FULL,
    output logic          OVF
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [3*NB-1:0] head;
    logic [3*NB-1:0] next_head;
    logic [CW-1:0]   count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            accept;
    logic            drop;

    emit_state_e     state;
    emit_state_e     state_nxt;
    logic [1:0]      phase;
    logic [1:0]      phase_nxt;
    logic [NB-1:0]   dout_nxt;
    logic            vout_nxt;

    // Word 0 is the oldest sample and sits in the top slice of an entry.
    function automatic logic [NB-1:0] word_of(input logic [3*NB-1:0] trip,
                                              input logic [1:0]       idx);
        case (idx)
            2'd0:    return trip[3*NB-1 -: NB];
            2'd1:    return trip[2*NB-1 -: NB];
            default: return trip[NB-1:0];
        endcase
    endfunction

    // The head retires on the edge that ends its last word, which is also the
    // edge on which a full FIFO can take a new triplet.
    assign pop    = (state == EMIT) && (phase == PHASE_LAST);
    assign accept = VIN && (!fifo_full || pop);
    assign drop   = VIN && !accept;
    assign FULL   = fifo_full;

    fir_triplet_fifo #(
        .W     (3*NB),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_n),
        .push      (accept),
        .din       ({DIN0, DIN1, DIN2}),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and output-word selection for the serializer.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        dout_nxt  = DOUT;
        vout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = EMIT;
                    phase_nxt = 2'd0;
                    dout_nxt  = word_of(head, 2'd0);
                    vout_nxt  = 1'b1;
                end
            end
            EMIT: begin
                if (phase != PHASE_LAST) begin
                    phase_nxt = phase + 2'd1;
                    dout_nxt  = word_of(head, phase + 2'd1);
                    vout_nxt  = 1'b1;
                end else if (count > CNT_ONE) begin
                    // Another triplet is already stored behind the head: chain it.
                    phase_nxt = 2'd0;
                    dout_nxt  = word_of(next_head, 2'd0);
                    vout_nxt  = 1'b1;
                end else begin
                    // Nothing behind the head; DOUT keeps its last word.
                    state_nxt = IDLE;
                    phase_nxt = 2'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = 2'd0;
            end
        endcase
    end

    // FSM, phase, output register and sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= IDLE;
            phase <= 2'd0;
            DOUT  <= '0;
            VOUT  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            DOUT  <= dout_nxt;
            VOUT  <= vout_nxt;
            OVF   <= OVF | drop;
        end
    end

endmodule

// File: tb/tb_fir_out_serializer.sv
// Bench for fir_out_serializer: queue-based reference model plus directed tests.
module tb_fir_out_serializer;

    localparam int NB    = 8;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST_n = 1'b0;
    logic          VIN = 1'b0;
    logic [NB-1:0] DIN0 = '0;
    logic [NB-1:0] DIN1 = '0;
    logic [NB-1:0] DIN2 = '0;
    logic [NB-1:0] DOUT;
    logic          VOUT;
    logic          FULL;
    logic          OVF;

    fir_out_serializer #(.NB(NB), .DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .RST_n(RST_n),
        .VIN  (VIN),
        .DIN0 (DIN0),
        .DIN1 (DIN1),
        .DIN2 (DIN2),
        .DOUT (DOUT),
        .VOUT (VOUT),
        .FULL (FULL),
        .OVF  (OVF)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stored triplets, the one being shown, how many of its
    // words have been shown so far.
    logic [3*NB-1:0] mq[$];
    bit              m_busy = 0;
    int              m_pos = 0;
    logic [NB-1:0]   exp_dout = '0;
    logic            exp_vout = 0;
    logic            exp_ovf = 0;

    function automatic logic [NB-1:0] wsel(input logic [3*NB-1:0] t, input int i);
        logic [3*NB-1:0] s;
        s = t >> (NB * (2 - i));
        return s[NB-1:0];
    endfunction

    initial forever begin
        bit pop_now;
        bit acc;
        @(posedge CLK);
        if (!RST_n) begin
            mq.delete();
            m_busy = 0; m_pos = 0;
            exp_dout = '0; exp_vout = 0; exp_ovf = 0;
        end else begin
            pop_now = m_busy && (m_pos == 3);
            acc     = VIN && ((mq.size() < DEPTH) || pop_now);
            if (VIN && !acc) exp_ovf = 1;
            if (pop_now) begin
                void'(mq.pop_front());
                m_busy = 0;
            end
            if (m_busy) begin
                exp_dout = wsel(mq[0], m_pos);
                m_pos++;
                exp_vout = 1;
            end else if (mq.size() > 0) begin
                m_busy = 1;
                exp_dout = wsel(mq[0], 0);
                m_pos = 1;
                exp_vout = 1;
            end else begin
                exp_vout = 0;
            end
            if (acc) mq.push_back({DIN0, DIN1, DIN2});
        end
    end

    // Per-cycle compare against the model, plus stream capture for order checks.
    bit            chk_en = 0;
    logic [NB-1:0] got_q[$];
    int            run = 0;
    int            max_run = 0;
    bit            saw_full = 0;

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            chk("vout", VOUT, exp_vout);
            chk("dout", DOUT, exp_dout);
            chk("full", FULL, mq.size() == DEPTH);
            chk("ovf",  OVF,  exp_ovf);
            if (VOUT === 1'b1) begin
                got_q.push_back(DOUT);
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (FULL === 1'b1) saw_full = 1;
        end
    end

    // Hold the given inputs across exactly one rising edge (call at a negedge).
    task automatic drive(input bit v, input int a, input int b, input int c);
        VIN  = v;
        DIN0 = a[NB-1:0];
        DIN1 = b[NB-1:0];
        DIN2 = c[NB-1:0];
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        idle(1);
        RST_n = 1'b1;
    endtask

    task automatic chk_stream(input string nm, input int exp_q[$]);
        chk({nm, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk(nm, got_q[i], exp_q[i][NB-1:0]);
        end
    endtask

    initial begin
        int eq[$];

        // Reset state.
        @(negedge CLK);
        idle(1);
        chk("rst_dout", DOUT, 0);
        chk("rst_vout", VOUT, 0);
        chk("rst_full", FULL, 0);
        chk("rst_ovf",  OVF,  0);
        RST_n  = 1'b1;
        chk_en = 1;
        idle(2);

        // Single triplet, DIN0 appears after edge t+1.
        drive(1, 10, 20, 30);
        drive(0, 0, 0, 0);
        chk("t1_w0", DOUT, 10); chk("t1_v0", VOUT, 1);
        drive(0, 0, 0, 0);
        chk("t1_w1", DOUT, 20); chk("t1_v1", VOUT, 1);
        drive(0, 0, 0, 0);
        chk("t1_w2", DOUT, 30); chk("t1_v2", VOUT, 1);
        drive(0, 0, 0, 0);
        chk("t1_end_v", VOUT, 0); chk("t1_hold", DOUT, 30);
        idle(2);

        // Signed extremes pass through untouched.
        drive(1, -128, 127, -1);
        drive(0, 0, 0, 0);
        chk("sgn_w0", DOUT, 8'h80);
        drive(0, 0, 0, 0);
        chk("sgn_w1", DOUT, 8'h7F);
        drive(0, 0, 0, 0);
        chk("sgn_w2", DOUT, 8'hFF);
        idle(3);

        // One triplet every third cycle: gapless 60-word stream.
        got_q.delete(); max_run = 0; saw_full = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1, 3*k+1, 3*k+2, 3*k+3);
            idle(2);
        end
        idle(6);
        eq.delete();
        for (int i = 1; i <= 60; i++) eq.push_back(i);
        chk_stream("s36", eq);
        chk("s36_run", max_run, 60);
        chk("s36_full", saw_full, 0);
        chk("s36_ovf", OVF, 0);

        // Full FIFO takes a triplet on the edge the head retires.
        do_reset();
        got_q.delete();
        for (int k = 0; k < 4; k++) drive(1, 3*k+1, 3*k+2, 3*k+3);
        chk("s38_full4", FULL, 1);
        drive(1, 13, 14, 15);
        chk("s38_full5", FULL, 1);
        chk("s38_ovf", OVF, 0);
        idle(20);
        eq.delete();
        for (int i = 1; i <= 15; i++) eq.push_back(i);
        chk_stream("s38", eq);
        chk("s38_ovf_end", OVF, 0);

        // Burst of 8: triplets 6 and 7 dropped, OVF sticky.
        do_reset();
        got_q.delete();
        for (int k = 0; k < 8; k++) drive(1, 3*k+1, 3*k+2, 3*k+3);
        chk("s37_ovf", OVF, 1);
        idle(24);
        eq.delete();
        for (int i = 1; i <= 15; i++) eq.push_back(i);
        for (int i = 22; i <= 24; i++) eq.push_back(i);
        chk_stream("s37", eq);
        chk("s37_ovf_sticky", OVF, 1);
        chk("s37_full_end", FULL, 0);

        // Reset mid-triplet (phase 1), OVF still set from the burst above.
        drive(1, 8'h11, 8'h22, 8'h33);
        drive(0, 0, 0, 0);
        chk("r40_w0", DOUT, 8'h11);
        drive(0, 0, 0, 0);
        chk("r40_w1", DOUT, 8'h22);
        RST_n = 1'b0;
        idle(1);
        chk("r40_dout", DOUT, 0);
        chk("r40_vout", VOUT, 0);
        chk("r40_ovf",  OVF,  0);
        RST_n = 1'b1;
        got_q.delete();
        idle(8);
        chk("r40_quiet", got_q.size(), 0);
        drive(1, 5, 6, 7);
        idle(6);
        eq.delete();
        eq.push_back(5); eq.push_back(6); eq.push_back(7);
        chk_stream("r40_new", eq);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
